// File: rtl/pc_stack16.sv
// pc_stack16: Hack-style program counter with a hardware return-address stack.
// Priority per cycle: reset > call > ret > load > inc > hold.
// out, depth, overflow and underflow are registered; empty/full decode depth.
module pc_stack16 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in,
  input  logic                     load,
  input  logic                     inc,
  input  logic                     call,
  input  logic                     ret,
  output logic [WIDTH-1:0]         out,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  // Address increment wraps modulo 2^WIDTH without any flag.
  function automatic logic [WIDTH-1:0] addr_inc(input logic [WIDTH-1:0] a);
    return a + 1'b1;
  endfunction

  logic [WIDTH-1:0] stack_mem [DEPTH];

  logic [WIDTH-1:0] out_nxt;
  logic [AW:0]      depth_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic             push_en;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;
  logic [WIDTH-1:0] push_data;

  // Stack pointer decode: push into the slot at depth, pop from depth-1.
  // When full, the low bits of depth are zero and depth-1 wraps to the top slot.
  assign push_idx  = depth[AW-1:0];
  assign pop_idx   = depth[AW-1:0] - 1'b1;
  assign push_data = addr_inc(out);

  // Status flags decoded straight from the registered depth.
  assign empty = (depth == '0);
  assign full  = (depth == DEPTH_V);

  // Next-state selection, one action per cycle in priority order.
  always_comb begin
    out_nxt   = out;
    depth_nxt = depth;
    ovf_nxt   = overflow;
    unf_nxt   = underflow;
    push_en   = 1'b0;
    if (call) begin
      // The jump happens even when the push has to be dropped.
      out_nxt = in;
      if (full) begin
        ovf_nxt = 1'b1;
      end else begin
        push_en   = 1'b1;
        depth_nxt = depth + 1'b1;
      end
    end else if (ret) begin
      if (empty) begin
        unf_nxt = 1'b1;
      end else begin
        out_nxt   = stack_mem[pop_idx];
        depth_nxt = depth - 1'b1;
      end
    end else if (load) begin
      out_nxt = in;
    end else if (inc) begin
      out_nxt = addr_inc(out);
    end
  end

  // Stack storage: data only, never reset; a reset cycle suppresses the push.
  always_ff @(posedge clk) begin
    if (push_en && !reset) begin
      stack_mem[push_idx] <= push_data;
    end
  end

  // Program counter, stack depth and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out       <= out_nxt;
      depth     <= depth_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

endmodule

// File: tb/tb_pc_stack16.sv
// tb_pc_stack16: directed sequence with a scoreboard queue of expected states.
module tb_pc_stack16;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load, inc, call, ret;
  logic [15:0] out;
  logic [2:0]  depth;
  logic        empty, full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] out;
    logic [2:0]  depth;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];

  pc_stack16 #(.WIDTH(16), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .load      (load),
    .inc       (inc),
    .call      (call),
    .ret       (ret),
    .out       (out),
    .depth     (depth),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of controls, queue the expected result, then compare after the edge.
  task automatic step(input string tag,
                      input logic r, input logic c, input logic rt,
                      input logic ld, input logic ic, input logic [15:0] din,
                      input logic [15:0] e_out, input logic [2:0] e_depth,
                      input logic e_ovf, input logic e_unf);
    exp_t e;
    exp_t g;
    string t;
    reset = r; call = c; ret = rt; load = ld; inc = ic; in = din;
    e.out = e_out; e.depth = e_depth; e.ovf = e_ovf; e.unf = e_unf;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".out"},   32'(out),       32'(g.out));
    chk({t, ".depth"}, 32'(depth),     32'(g.depth));
    chk({t, ".empty"}, 32'(empty),     32'(g.depth == 3'd0));
    chk({t, ".full"},  32'(full),      32'(g.depth == 3'd4));
    chk({t, ".ovf"},   32'(overflow),  32'(g.ovf));
    chk({t, ".unf"},   32'(underflow), 32'(g.unf));
  endtask

  initial begin
    reset = 1'b0; in = '0; load = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0;
    #2;
    //   tag           rst call ret ld inc in         out      d  ovf unf
    // Reset then increment
    step("rst0",       1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    step("inc1",       0, 0, 0, 0, 1, 16'h0000, 16'h0001, 0, 0, 0);
    step("inc2",       0, 0, 0, 0, 1, 16'h0000, 16'h0002, 0, 0, 0);
    step("inc3",       0, 0, 0, 0, 1, 16'h0000, 16'h0003, 0, 0, 0);
    step("hold",       0, 0, 0, 0, 0, 16'h7777, 16'h0003, 0, 0, 0);
    // Call then return
    step("ld10",       0, 0, 0, 1, 0, 16'h0010, 16'h0010, 0, 0, 0);
    step("call200",    0, 1, 0, 0, 0, 16'h0200, 16'h0200, 1, 0, 0);
    step("ret11",      0, 0, 1, 0, 0, 16'h0000, 16'h0011, 0, 0, 0);
    // Fill the stack and overflow it
    step("rst1",       1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    step("c100",       0, 1, 0, 0, 0, 16'h0100, 16'h0100, 1, 0, 0);
    step("c200",       0, 1, 0, 0, 0, 16'h0200, 16'h0200, 2, 0, 0);
    step("c300",       0, 1, 0, 0, 0, 16'h0300, 16'h0300, 3, 0, 0);
    step("c400",       0, 1, 0, 0, 0, 16'h0400, 16'h0400, 4, 0, 0);
    step("c500ovf",    0, 1, 0, 0, 0, 16'h0500, 16'h0500, 4, 1, 0);
    step("r301",       0, 0, 1, 0, 0, 16'h0000, 16'h0301, 3, 1, 0);
    step("r201",       0, 0, 1, 0, 0, 16'h0000, 16'h0201, 2, 1, 0);
    step("r101",       0, 0, 1, 0, 0, 16'h0000, 16'h0101, 1, 1, 0);
    step("r001",       0, 0, 1, 0, 0, 16'h0000, 16'h0001, 0, 1, 0);
    // Underflow is sticky until reset
    step("rst2",       1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    step("ld1234",     0, 0, 0, 1, 0, 16'h1234, 16'h1234, 0, 0, 0);
    step("retempty",   0, 0, 1, 0, 0, 16'h0000, 16'h1234, 0, 0, 1);
    step("unfsticky",  0, 0, 0, 0, 1, 16'h0000, 16'h1235, 0, 0, 1);
    step("rst3",       1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    // Wrap and priority of call over load/inc
    step("ldFFFF",     0, 0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0);
    step("wrap",       0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
    step("callwins",   0, 1, 0, 1, 1, 16'h0042, 16'h0042, 1, 0, 0);
    step("top0001",    0, 0, 1, 0, 0, 16'h0000, 16'h0001, 0, 0, 0);
    // Reset between call and ret discards the stack
    step("rst4",       1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    step("c300b",      0, 1, 0, 0, 0, 16'h0300, 16'h0300, 1, 0, 0);
    step("rstmid",     1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    step("retafter",   0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
    // Further priority cases
    step("rst5",       1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    step("ldwinsinc",  0, 0, 0, 1, 1, 16'h0050, 16'h0050, 0, 0, 0);
    step("c60",        0, 1, 0, 0, 0, 16'h0060, 16'h0060, 1, 0, 0);
    step("retwinsld",  0, 0, 1, 1, 1, 16'h0999, 16'h0051, 0, 0, 0);
    step("c70",        0, 1, 0, 0, 0, 16'h0070, 16'h0070, 1, 0, 0);
    step("rstwins",    1, 1, 1, 1, 1, 16'h0abc, 16'h0000, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
